// File: rtl/gmii_rx_frame_if.sv
// GMII receive byte stream in; payload stream, frame status and counters out.
// master = the frame receiver, slave = the PHY/consumer side.
interface gmii_rx_frame_if;
    logic        gmii_rx_dv;
    logic        gmii_rx_err;
    logic [7:0]  gmii_rd;
    logic        out_valid;
    logic        out_sof;
    logic [7:0]  out_data;
    logic        frame_done;
    logic        frame_ok;
    logic        frame_crc_err;
    logic        frame_len_err;
    logic        frame_rx_err;
    logic [15:0] frame_len;
    logic [31:0] cnt_good;
    logic [31:0] cnt_bad;

    modport master (
        input  gmii_rx_dv, gmii_rx_err, gmii_rd,
        output out_valid, out_sof, out_data,
        output frame_done, frame_ok, frame_crc_err, frame_len_err, frame_rx_err, frame_len,
        output cnt_good, cnt_bad
    );

    modport slave (
        output gmii_rx_dv, gmii_rx_err, gmii_rd,
        input  out_valid, out_sof, out_data,
        input  frame_done, frame_ok, frame_crc_err, frame_len_err, frame_rx_err, frame_len,
        input  cnt_good, cnt_bad
    );
endinterface

// File: rtl/gmii_rx_frame.sv
// GMII receive front end: strips preamble/SFD/FCS, checks CRC-32, length and
// rx_err, posts a per-frame status strobe and keeps good/bad frame counters.
module gmii_rx_frame #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic            gmii_rxc,
    input  logic            rst_n,
    gmii_rx_frame_if.master bus
);
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [15:0] MIN_L = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L = 16'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, PRE, DATA, DONE, DROP} state_t;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    state_t          state;
    logic            dv_q, err_q, prev_dv;
    logic [7:0]      rd_q;
    logic [2:0][7:0] dly;
    logic [31:0]     crc;
    logic [15:0]     len;
    logic            rx_err;

    logic            out_valid, out_sof, frame_done, frame_ok;
    logic            frame_crc_err, frame_len_err, frame_rx_err;
    logic [7:0]      out_data;
    logic [15:0]     frame_len;
    logic [31:0]     cnt_good, cnt_bad;

    logic rise, crc_ok, len_bad, ok;
    assign rise    = dv_q & ~prev_dv;
    assign crc_ok  = (crc == CRC_RESIDUE);
    assign len_bad = (len < MIN_L) || (len > MAX_L);
    assign ok      = crc_ok & ~len_bad & ~rx_err;

    assign bus.out_valid     = out_valid;
    assign bus.out_sof       = out_sof;
    assign bus.out_data      = out_data;
    assign bus.frame_done    = frame_done;
    assign bus.frame_ok      = frame_ok;
    assign bus.frame_crc_err = frame_crc_err;
    assign bus.frame_len_err = frame_len_err;
    assign bus.frame_rx_err  = frame_rx_err;
    assign bus.frame_len     = frame_len;
    assign bus.cnt_good      = cnt_good;
    assign bus.cnt_bad       = cnt_bad;

    // dv_q resets high together with prev_dv so a frame already streaming at
    // reset release can never look like a fresh dv rise.
    always_ff @(posedge gmii_rxc or negedge rst_n) begin
        if (!rst_n) begin
            dv_q  <= 1'b1;
            err_q <= 1'b0;
            rd_q  <= '0;
        end else begin
            dv_q  <= bus.gmii_rx_dv;
            err_q <= bus.gmii_rx_err;
            rd_q  <= bus.gmii_rd;
        end
    end

    always_ff @(posedge gmii_rxc or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            prev_dv       <= 1'b1;
            dly           <= '0;
            crc           <= '0;
            len           <= '0;
            rx_err        <= 1'b0;
            out_valid     <= 1'b0;
            out_sof       <= 1'b0;
            out_data      <= '0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            frame_crc_err <= 1'b0;
            frame_len_err <= 1'b0;
            frame_rx_err  <= 1'b0;
            frame_len     <= '0;
            cnt_good      <= '0;
            cnt_bad       <= '0;
        end else begin
            prev_dv    <= dv_q;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                // DONE also watches for a start so a one-cycle inter-frame gap works.
                IDLE, DONE: begin
                    dly   <= '0;
                    state <= IDLE;
                    if (rise) begin
                        if (err_q || rd_q != 8'h55) begin
                            state   <= DROP;
                            cnt_bad <= cnt_bad + 32'd1;
                        end else begin
                            state <= PRE;
                        end
                    end
                end
                PRE: begin
                    if (!dv_q) begin
                        state <= IDLE;
                    end else if (err_q || (rd_q != 8'h55 && rd_q != 8'hD5)) begin
                        state   <= DROP;
                        cnt_bad <= cnt_bad + 32'd1;
                    end else if (rd_q == 8'hD5) begin
                        state  <= DATA;
                        crc    <= 32'hFFFFFFFF;
                        len    <= '0;
                        rx_err <= 1'b0;
                    end
                end
                DATA: begin
                    if (dv_q) begin
                        crc <= crc_byte(crc, rd_q);
                        if (len != 16'hFFFF)
                            len <= len + 16'd1;
                        if (err_q)
                            rx_err <= 1'b1;
                        dly <= {dly[1:0], rd_q};
                        // Byte len-3 is payload only if a 4th successor exists; the
                        // live dv shows that one cycle early and saves a cycle of latency.
                        if (len >= 16'd3 && bus.gmii_rx_dv) begin
                            out_valid <= 1'b1;
                            out_sof   <= (len == 16'd3);
                            out_data  <= dly[2];
                        end
                    end else begin
                        state         <= DONE;
                        frame_done    <= 1'b1;
                        frame_ok      <= ok;
                        frame_crc_err <= ~crc_ok;
                        frame_len_err <= len_bad;
                        frame_rx_err  <= rx_err;
                        frame_len     <= len;
                        if (ok)
                            cnt_good <= cnt_good + 32'd1;
                        else
                            cnt_bad  <= cnt_bad + 32'd1;
                    end
                end
                DROP: begin
                    if (!dv_q)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
